// File: rtl/ddr3_test_pkg.sv
// Shared definitions for the DDR3 Avalon pattern tester: FSM encodings,
// error-counter width and the address-derived test pattern.
package ddr3_test_pkg;

   localparam int ERR_CNT_W = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   function automatic logic [63:0] pattern_word(input logic [31:0] addr, input logic [31:0] seed);
      logic [31:0] v;
      v = addr ^ seed;
      return {~v, v};
   endfunction

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Combinational word-address -> DATA_W test pattern ({~v, v} replicated).
module ddr3_pattern_gen
   import ddr3_test_pkg::*;
#(
   parameter int          ADDR_W = 25,
   parameter int          DATA_W = 64,
   parameter logic [31:0] SEED   = 32'hA5C3_0F1E
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] o_data
);

   logic [31:0] w_addr32;

   generate
      if (ADDR_W >= 32) begin : g_trunc
         assign w_addr32 = i_addr[31:0];
      end else begin : g_zext
         assign w_addr32 = {{(32-ADDR_W){1'b0}}, i_addr};
      end
   endgenerate

   assign o_data = {(DATA_W/64){pattern_word(w_addr32, SEED)}};

endmodule

// File: rtl/ddr3_avl_pattern_tester.sv
// Avalon-MM memory tester for the DDR3 EMIF user port: write an address-derived
// pattern to N_WORDS words, read them back in order, count mismatches.
module ddr3_avl_pattern_tester
   import ddr3_test_pkg::*;
#(
   parameter int          ADDR_W          = 25,
   parameter int          DATA_W          = 64,
   parameter int          N_WORDS         = 1024,
   parameter int          MAX_OUTSTANDING = 8,
   parameter logic [31:0] SEED            = 32'hA5C3_0F1E,
   parameter int          TIMEOUT_CYCLES  = 4096
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_init_done,
   input  logic                 i_cal_success,
   input  logic                 i_start,
   output logic [ADDR_W-1:0]    o_avm_address,
   output logic                 o_avm_write,
   output logic                 o_avm_read,
   output logic [DATA_W-1:0]    o_avm_writedata,
   output logic [DATA_W/8-1:0]  o_avm_byteenable,
   input  logic                 i_avm_waitrequest,
   input  logic [DATA_W-1:0]    i_avm_readdata,
   input  logic                 i_avm_readdatavalid,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic                 o_timeout,
   output logic [ERR_CNT_W-1:0] o_err_count,
   output logic [ADDR_W-1:0]    o_first_err_addr
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int OST_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N_WORDS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
   localparam logic [OST_W-1:0]  MAX_OST   = OST_W'(MAX_OUTSTANDING);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]           r_state;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_write, r_read;
   logic [CNT_W-1:0]     r_iss_cnt, r_rx_cnt;
   logic [OST_W-1:0]     r_outst;
   logic [TO_W-1:0]      r_to_cnt;
   logic                 r_busy, r_done, r_timeout, r_mis;
   logic [ADDR_W-1:0]    r_mis_addr, r_first_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic                 w_ready, w_rd_phase, w_wr_acc, w_rd_acc, w_rdv, w_rd_nxt, w_to_hit, w_mis;
   logic [OST_W-1:0]     w_outst_nxt;
   logic [CNT_W-1:0]     w_iss_nxt;
   logic [DATA_W-1:0]    w_wdata, w_exp;

   ddr3_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
      .i_addr(r_addr), .o_data(w_wdata));

   // Expected data follows the return count, since returns are in order.
   ddr3_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) u_exp_gen (
      .i_addr(r_rx_cnt[ADDR_W-1:0]), .o_data(w_exp));

   assign w_ready     = i_init_done & i_cal_success;
   assign w_rd_phase  = (r_state == ST_READ) || (r_state == ST_DRAIN);
   assign w_wr_acc    = r_write & ~i_avm_waitrequest;
   assign w_rd_acc    = r_read & ~i_avm_waitrequest;
   assign w_rdv       = i_avm_readdatavalid & w_rd_phase & (r_outst != '0);
   assign w_outst_nxt = r_outst + OST_W'(w_rd_acc) - OST_W'(w_rdv);
   assign w_iss_nxt   = r_iss_cnt + CNT_W'(w_rd_acc);
   // A stalled read keeps both terms unchanged, so the request stays asserted.
   assign w_rd_nxt    = (w_outst_nxt < MAX_OST) && (w_iss_nxt < N_CNT);
   assign w_to_hit    = !w_rdv && (r_outst != '0) && (r_to_cnt == TO_LAST);
   assign w_mis       = w_rdv && (i_avm_readdata != w_exp);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;   r_addr <= '0;      r_write <= 1'b0;   r_read <= 1'b0;
         r_iss_cnt <= '0;      r_rx_cnt <= '0;    r_outst <= '0;     r_to_cnt <= '0;
         r_busy <= 1'b0;       r_done <= 1'b0;    r_timeout <= 1'b0; r_mis <= 1'b0;
         r_mis_addr <= '0;     r_first_err <= '0; r_err_cnt <= '0;
      end else begin
         r_mis      <= w_mis;
         r_mis_addr <= r_rx_cnt[ADDR_W-1:0];
         if (r_mis) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (r_err_cnt == '0) r_first_err <= r_mis_addr;
         end
         if (w_rdv) r_rx_cnt <= r_rx_cnt + 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (i_start && w_ready) begin
                  r_state <= ST_WRITE;  r_write <= 1'b1;   r_addr <= '0;
                  r_iss_cnt <= '0;      r_rx_cnt <= '0;    r_outst <= '0;     r_to_cnt <= '0;
                  r_busy <= 1'b1;       r_done <= 1'b0;    r_timeout <= 1'b0;
                  r_mis <= 1'b0;        r_err_cnt <= '0;   r_first_err <= '0;
               end
            end
            ST_WRITE: begin
               if (!w_ready) begin
                  r_state <= ST_DONE; r_write <= 1'b0; r_busy <= 1'b0; r_done <= 1'b1; r_timeout <= 1'b1;
               end else if (w_wr_acc) begin
                  if (r_addr == LAST_ADDR) begin
                     r_state <= ST_READ; r_write <= 1'b0; r_read <= 1'b1; r_addr <= '0;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
            end
            ST_READ, ST_DRAIN: begin
               if (!w_ready || w_to_hit) begin
                  r_state <= ST_DONE; r_read <= 1'b0; r_busy <= 1'b0; r_done <= 1'b1; r_timeout <= 1'b1;
               end else begin
                  r_outst   <= w_outst_nxt;
                  r_iss_cnt <= w_iss_nxt;
                  r_read    <= w_rd_nxt;
                  if (w_rd_nxt) r_addr <= w_iss_nxt[ADDR_W-1:0];
                  r_to_cnt  <= (w_rdv || r_outst == '0) ? '0 : r_to_cnt + 1'b1;
                  if (r_state == ST_READ && w_iss_nxt == N_CNT) r_state <= ST_DRAIN;
                  if (r_state == ST_DRAIN && r_rx_cnt == N_CNT) begin
                     r_state <= ST_DONE; r_busy <= 1'b0; r_done <= 1'b1;
                  end
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_avm_address    = r_addr;
   assign o_avm_write      = r_write;
   assign o_avm_read       = r_read;
   assign o_avm_writedata  = r_write ? w_wdata : '0;
   assign o_avm_byteenable = '1;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_pass           = r_done && (r_err_cnt == '0) && !r_timeout;
   assign o_timeout        = r_timeout;
   assign o_err_count      = r_err_cnt;
   assign o_first_err_addr = r_first_err;

endmodule

// File: tb/tb_ddr3_avl_pattern_tester.sv
// Directed bench: reactive Avalon slave model, table of run configurations
// with expected results, plus hand-written calibration-loss and reset sequences.
module tb_ddr3_avl_pattern_tester;

   localparam int AW = 8;
   localparam int DW = 128;
   localparam int NW = 16;
   localparam int MO = 8;
   localparam int TO = 64;
   localparam logic [31:0] SEED = 32'hA5C3_0F1E;

   logic clk, rst, init_done, cal_success, start;
   logic [AW-1:0]   avm_address;
   logic            avm_write, avm_read;
   logic [DW-1:0]   avm_writedata;
   logic [DW/8-1:0] avm_byteenable;
   logic            avm_waitrequest;
   logic [DW-1:0]   avm_readdata;
   logic            avm_readdatavalid;
   logic            busy, done, pass, timeout;
   logic [15:0]     err_count;
   logic [AW-1:0]   first_err_addr;

   ddr3_avl_pattern_tester #(
      .ADDR_W(AW), .DATA_W(DW), .N_WORDS(NW), .MAX_OUTSTANDING(MO), .SEED(SEED), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_init_done(init_done), .i_cal_success(cal_success), .i_start(start),
      .o_avm_address(avm_address), .o_avm_write(avm_write), .o_avm_read(avm_read),
      .o_avm_writedata(avm_writedata), .o_avm_byteenable(avm_byteenable),
      .i_avm_waitrequest(avm_waitrequest), .i_avm_readdata(avm_readdata),
      .i_avm_readdatavalid(avm_readdatavalid),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(timeout),
      .o_err_count(err_count), .o_first_err_addr(first_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk, n_pass;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] pat(input int a);
      logic [31:0] v;
      v = 32'(a) ^ SEED;
      return {~v, v, ~v, v};
   endfunction

   // slave model configuration and monitors
   int  wait_pct, lat, bad_idx, cyc, out_cnt, max_out, wr_exp, wr_bad, stall_bad, last_rdv;
   bit  drop_last, slv_clear, chk_en, prev_stall;
   logic [DW+AW+1:0] prev_cmd;
   logic [DW-1:0] mem [NW];

   typedef struct { int due; logic [DW-1:0] d; } rsp_t;
   rsp_t q[$];

   always @(posedge clk) begin
      rsp_t e;
      cyc++;
      if (slv_clear) begin
         q.delete(); out_cnt = 0; max_out = 0; prev_stall = 0; wr_exp = 0; wr_bad = 0; stall_bad = 0;
         avm_readdatavalid <= 1'b0; avm_waitrequest <= 1'b0;
      end else begin
         if (chk_en && prev_stall && prev_cmd !== {avm_write, avm_read, avm_address, avm_writedata})
            stall_bad++;
         prev_stall = (avm_write | avm_read) & avm_waitrequest;
         prev_cmd   = {avm_write, avm_read, avm_address, avm_writedata};
         if (avm_write && !avm_waitrequest) begin
            if (avm_address != AW'(wr_exp) || avm_writedata != pat(int'(avm_address))) wr_bad++;
            wr_exp++;
            mem[avm_address[3:0]] = avm_writedata;
         end
         if (avm_read && !avm_waitrequest) begin
            out_cnt++;
            if (!(drop_last && int'(avm_address) == NW-1)) begin
               e.d = mem[avm_address[3:0]];
               if (int'(avm_address) == bad_idx) e.d[5] = ~e.d[5];
               e.due = cyc + lat - 1;
               q.push_back(e);
            end
         end
         if (avm_readdatavalid) begin out_cnt--; last_rdv = cyc; end
         if (out_cnt > max_out) max_out = out_cnt;
         if (q.size() != 0 && q[0].due <= cyc) begin
            avm_readdatavalid <= 1'b1;
            avm_readdata      <= q[0].d;
            void'(q.pop_front());
         end else begin
            avm_readdatavalid <= 1'b0;
         end
         avm_waitrequest <= ($urandom_range(0, 99) < wait_pct);
      end
   end

   task automatic clear_slave(input int wp, input int l, input int bad, input bit drop);
      @(negedge clk);
      slv_clear = 1; wait_pct = wp; lat = l; bad_idx = bad; drop_last = drop;
      @(negedge clk);
      slv_clear = 0;
   endtask

   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input string name);
      for (int c = 0; c < 3000 && !done; c++) @(negedge clk);
      chk({name, "_done"}, done, 1'b1);
   endtask

   typedef struct {
      string name; int wp; int l; int bad; bit drop;
      bit exp_pass; int exp_err; int exp_first; bit exp_to;
   } vec_t;
   vec_t vecs[4];

   initial begin
      int d;
      bit found;
      vecs[0] = '{"ideal",   0,  3, -1, 1'b0, 1'b1, 0, 0, 1'b0};
      vecs[1] = '{"bitflip", 0,  3,  7, 1'b0, 1'b0, 1, 7, 1'b0};
      vecs[2] = '{"stall",  50, 20, -1, 1'b0, 1'b1, 0, 0, 1'b0};
      vecs[3] = '{"droplst", 0,  3, -1, 1'b1, 1'b0, 0, 0, 1'b1};

      n_chk = 0; n_pass = 0; cyc = 0; chk_en = 0; slv_clear = 1;
      wait_pct = 0; lat = 3; bad_idx = -1; drop_last = 0;
      avm_readdata = '0; avm_readdatavalid = 0; avm_waitrequest = 0;
      rst = 1; init_done = 1; cal_success = 1; start = 0;
      repeat (3) @(negedge clk);
      chk("rst_addr",  avm_address, '0);
      chk("rst_rw",    {avm_write, avm_read}, '0);
      chk("rst_wdata", avm_writedata, '0);
      chk("rst_be",    avm_byteenable, {(DW/8){1'b1}});
      chk("rst_flags", {busy, done, pass, timeout, err_count, first_err_addr}, '0);
      rst = 0;

      chk_en = 1;
      for (int i = 0; i < 4; i++) begin
         clear_slave(vecs[i].wp, vecs[i].l, vecs[i].bad, vecs[i].drop);
         pulse_start();
         chk({vecs[i].name, "_busy"}, busy, 1'b1);
         wait_done(vecs[i].name);
         chk({vecs[i].name, "_pass"},  pass, vecs[i].exp_pass);
         chk({vecs[i].name, "_err"},   err_count, 16'(vecs[i].exp_err));
         chk({vecs[i].name, "_first"}, first_err_addr, AW'(vecs[i].exp_first));
         chk({vecs[i].name, "_tmo"},   timeout, vecs[i].exp_to);
         chk({vecs[i].name, "_wrbad"}, wr_bad, 0);
         chk({vecs[i].name, "_stall"}, stall_bad, 0);
         chk({vecs[i].name, "_maxout"}, (max_out <= MO && max_out >= 1), 1'b1);
         if (vecs[i].drop) begin
            d = cyc - last_rdv;
            chk("droplst_window", (d >= 48 && d <= TO), 1'b1);
         end
      end
      chk_en = 0;

      // start without calibration is ignored
      clear_slave(0, 3, -1, 0);
      cal_success = 0;
      pulse_start();
      repeat (3) @(negedge clk);
      chk("nocal_busy", {busy, avm_write}, '0);
      chk("nocal_done_held", done, 1'b1);
      cal_success = 1;

      // calibration lost mid-READ
      pulse_start();
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (avm_read) found = 1; else @(negedge clk);
      end
      chk("calloss_reached_read", found, 1'b1);
      cal_success = 0;
      @(negedge clk);
      chk("calloss_flags", {busy, done, timeout, pass}, 4'b0110);
      cal_success = 1;

      // reset during WRITE word 5
      clear_slave(0, 3, -1, 0);
      pulse_start();
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (avm_write && avm_address == 8'd5) found = 1; else @(negedge clk);
      end
      chk("rstmid_reached_w5", found, 1'b1);
      rst = 1;
      @(negedge clk);
      chk("rstmid_addr",  avm_address, '0);
      chk("rstmid_rw",    {avm_write, avm_read}, '0);
      chk("rstmid_wdata", avm_writedata, '0);
      chk("rstmid_flags", {busy, done, pass, timeout, err_count, first_err_addr}, '0);
      rst = 0;
      clear_slave(0, 3, -1, 0);
      pulse_start();
      wait_done("rerun");
      chk("rerun_pass",  pass, 1'b1);
      chk("rerun_wrbad", wr_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
